// File: rtl/baud_gen_frac.sv
// Fractional-N baud / oversample tick generator.
// A phase accumulator advances by incActive each enabled cycle. Its carry is the
// oversample tick. An oversample counter divides that tick down to the baud tick
// and to the mid-bit sample point.
//
// Strobe semantics: IncLoad and Resync are single-cycle strobes. They are sampled
// on the rising Clock edge, need no acknowledge and are never back-pressured.
// Pending stays high from the IncLoad edge until the edge where the value is
// moved into incActive.
module baud_gen_frac #(
    parameter int ACC_WIDTH   = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_INC = 1208,
    parameter int PH_W        = $clog2(OVERSAMPLE)
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Enable,
    input  logic [ACC_WIDTH-1:0] Increment,
    input  logic                 IncLoad,
    input  logic                 Resync,
    output logic                 OversampleTick,
    output logic                 BaudTick,
    output logic                 MidTick,
    output logic [PH_W-1:0]      Phase,
    output logic                 Pending
);

    localparam logic [PH_W-1:0]      CNT_LAST    = PH_W'(OVERSAMPLE - 1);
    // The mid tick fires on the carry that moves the counter into OVERSAMPLE/2.
    localparam logic [PH_W-1:0]      CNT_PRE_MID = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [ACC_WIDTH-1:0] INC_RESET   = ACC_WIDTH'(DEFAULT_INC);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] incActive;
    logic [ACC_WIDTH-1:0] incPend;
    logic [PH_W-1:0]      cnt;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 cntWrap;
    logic                 applyNow;

    // Accumulator sum and the points at which a pending increment may be applied.
    // Applying only at a baud boundary, while stopped, or on resync keeps rate
    // changes glitch-free. The current baud period always finishes at the old rate.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, incActive};
        carry    = sum[ACC_WIDTH];
        cntWrap  = (cnt == CNT_LAST);
        applyNow = Resync | ~Enable | (carry & cntWrap);
    end

    assign Phase = cnt;

    // Phase accumulator, oversample counter and registered one-cycle tick pulses.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            acc            <= '0;
            cnt            <= '0;
            OversampleTick <= 1'b0;
            BaudTick       <= 1'b0;
            MidTick        <= 1'b0;
        end else if (Resync) begin
            acc            <= '0;
            cnt            <= '0;
            OversampleTick <= 1'b0;
            BaudTick       <= 1'b0;
            MidTick        <= 1'b0;
        end else if (Enable) begin
            acc            <= sum[ACC_WIDTH-1:0];
            OversampleTick <= carry;
            BaudTick       <= carry & cntWrap;
            MidTick        <= carry & (cnt == CNT_PRE_MID);
            if (carry) begin
                cnt <= cntWrap ? '0 : cnt + PH_W'(1);
            end
        end else begin
            OversampleTick <= 1'b0;
            BaudTick       <= 1'b0;
            MidTick        <= 1'b0;
        end
    end

    // Rate registers: a newly loaded value becomes pending, and is applied at the next apply point.
    // On a same-edge load plus apply, the old pending value moves to active and the new value stays pending.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            incActive <= INC_RESET;
            incPend   <= '0;
            Pending   <= 1'b0;
        end else begin
            if (applyNow && Pending) begin
                incActive <= incPend;
            end
            if (IncLoad) begin
                incPend <= Increment;
                Pending <= 1'b1;
            end else if (applyNow) begin
                Pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac with ACC_WIDTH=4, OVERSAMPLE=4, DEFAULT_INC=4.
// Each expected tick is a hand-computed record: edge number after the reset
// release, plus the OversampleTick, BaudTick and MidTick bits and Phase.
// The driver pushes these records into exp_q. The monitor pops one record for
// every cycle in which the DUT raises any tick.
module tb_baud_gen_frac;

    localparam int AW = 4;
    localparam int OS = 4;
    localparam int DI = 4;
    localparam int PW = 2;
    localparam int W  = 16 + 3 + PW;

    logic          Clock     = 1'b0;
    logic          Reset_n   = 1'b0;
    logic          Enable    = 1'b0;
    logic [AW-1:0] Increment = '0;
    logic          IncLoad   = 1'b0;
    logic          Resync    = 1'b0;
    logic          OversampleTick;
    logic          BaudTick;
    logic          MidTick;
    logic [PW-1:0] Phase;
    logic          Pending;

    int            total = 0;
    int            bad   = 0;
    logic [15:0]   edgeCnt;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  monAct;
    logic [W-1:0]  monExp;
    logic [W-1:0]  leftExp;

    baud_gen_frac #(
        .ACC_WIDTH  (AW),
        .OVERSAMPLE (OS),
        .DEFAULT_INC(DI),
        .PH_W       (PW)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Enable        (Enable),
        .Increment     (Increment),
        .IncLoad       (IncLoad),
        .Resync        (Resync),
        .OversampleTick(OversampleTick),
        .BaudTick      (BaudTick),
        .MidTick       (MidTick),
        .Phase         (Phase),
        .Pending       (Pending)
    );

    // Clock and reset-relative edge counter.
    initial forever #5 Clock = ~Clock;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) edgeCnt <= '0;
        else          edgeCnt <= edgeCnt + 16'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, required finish within 200000 time units");
        $fatal(1);
    end

    // Driver and check tasks.
    task automatic pushTick(input int e, input logic b, input logic m, input int ph);
        exp_q.push_back({16'(e), 1'b1, b, m, PW'(ph)});
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic waitEdge(input int n);
        while (int'(edgeCnt) < n) @(negedge Clock);
    endtask

    task automatic pulseLoad(input int v);
        IncLoad   = 1'b1;
        Increment = AW'(v);
        @(negedge Clock);
        IncLoad   = 1'b0;
    endtask

    // Monitor: whenever the DUT presents a tick, compare it with the next expected record.
    always @(negedge Clock) begin
        if (Reset_n && (OversampleTick || BaudTick || MidTick)) begin
            monAct = {edgeCnt, OversampleTick, BaudTick, MidTick, Phase};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tick_unexpected: got edge=%0d os=%0b baud=%0b mid=%0b phase=%0d, required no tick",
                         edgeCnt, OversampleTick, BaudTick, MidTick, Phase);
            end else begin
                monExp = exp_q.pop_front();
                if (monAct !== monExp) begin
                    bad++;
                    $display("FAIL tick: got edge=%0d os=%0b baud=%0b mid=%0b phase=%0d, required edge=%0d os=%0b baud=%0b mid=%0b phase=%0d",
                             monAct[W-1:W-16], monAct[PW+2], monAct[PW+1], monAct[PW], monAct[PW-1:0],
                             monExp[W-1:W-16], monExp[PW+2], monExp[PW+1], monExp[PW], monExp[PW-1:0]);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge Clock);
        check("reset_os",      OversampleTick, 0);
        check("reset_baud",    BaudTick, 0);
        check("reset_mid",     MidTick, 0);
        check("reset_phase",   Phase, 0);
        check("reset_pending", Pending, 0);

        // Default rate 4/16, then a load of 3 applied at the first baud edge.
        pushTick(4, 0, 0, 1);  pushTick(8, 0, 1, 2);  pushTick(12, 0, 0, 3);
        pushTick(16, 1, 0, 0); pushTick(22, 0, 0, 1); pushTick(27, 0, 1, 2);
        pushTick(32, 0, 0, 3);
        Enable  = 1'b1;
        Reset_n = 1'b1;
        waitEdge(1);
        pulseLoad(3);
        check("pending_set", Pending, 1);
        waitEdge(15);
        check("pending_held", Pending, 1);
        waitEdge(16);
        check("pending_applied", Pending, 0);

        // Enable dropped for 10 cycles at Phase 2 with 6 of 16 accumulated.
        pushTick(38, 1, 0, 0); pushTick(43, 0, 0, 1); pushTick(48, 0, 1, 2);
        pushTick(64, 0, 0, 3); pushTick(69, 1, 0, 0);
        waitEdge(50);
        Enable = 1'b0;
        waitEdge(55);
        check("hold_phase_mid", Phase, 2);
        waitEdge(60);
        check("hold_phase_end", Phase, 2);
        check("hold_no_tick", OversampleTick, 0);
        Enable = 1'b1;

        // Load 4, then Resync on the edge that would have carried.
        pushTick(78, 0, 0, 1); pushTick(82, 0, 1, 2); pushTick(86, 0, 0, 3);
        pushTick(90, 1, 0, 0);
        waitEdge(69);
        pulseLoad(4);
        check("pending_before_resync", Pending, 1);
        waitEdge(73);
        Resync = 1'b1;
        @(negedge Clock);
        Resync = 1'b0;
        check("resync_phase", Phase, 0);
        check("resync_pending", Pending, 0);
        check("resync_no_tick", OversampleTick, 0);

        // Back-to-back loads 5 then 7: only 7 is applied at edge 106.
        pushTick(94, 0, 0, 1);  pushTick(98, 0, 1, 2);  pushTick(102, 0, 0, 3);
        pushTick(106, 1, 0, 0); pushTick(109, 0, 0, 1); pushTick(111, 0, 1, 2);
        pushTick(113, 0, 0, 3); pushTick(116, 1, 0, 0);
        waitEdge(90);
        pulseLoad(5);
        waitEdge(92);
        pulseLoad(7);
        check("pending_overwrite", Pending, 1);
        waitEdge(105);
        check("pending_wait_baud", Pending, 1);
        waitEdge(106);
        check("pending_cleared_baud", Pending, 0);

        // Load 0: all ticks stop after the edge-116 boundary.
        waitEdge(113);
        pulseLoad(0);
        waitEdge(116);
        check("zero_inc_pending", Pending, 0);
        waitEdge(140);
        check("zero_inc_phase", Phase, 0);

        // Resync plus IncLoad on one edge: 8 becomes active and 2 stays pending.
        pushTick(145, 0, 0, 1); pushTick(147, 0, 1, 2);
        pulseLoad(8);
        waitEdge(142);
        Resync    = 1'b1;
        IncLoad   = 1'b1;
        Increment = AW'(2);
        @(negedge Clock);
        Resync  = 1'b0;
        IncLoad = 1'b0;
        check("resync_load_pending", Pending, 1);
        check("resync_load_phase", Phase, 0);

        // Asynchronous reset while MidTick is high and 2 is pending.
        waitEdge(147);
        #1;
        Reset_n = 1'b0;
        #1;
        check("async_reset_mid", MidTick, 0);
        check("async_reset_os", OversampleTick, 0);
        check("async_reset_phase", Phase, 0);
        check("async_reset_pending", Pending, 0);
        pushTick(4, 0, 0, 1);   pushTick(8, 0, 1, 2);  pushTick(12, 0, 0, 3);
        pushTick(16, 1, 0, 0);  pushTick(20, 0, 0, 1); pushTick(24, 0, 1, 2);
        @(negedge Clock);
        @(negedge Clock);
        check("reset_hold_baud", BaudTick, 0);
        Reset_n = 1'b1;
        waitEdge(20);
        check("post_reset_pending", Pending, 0);
        waitEdge(26);

        while (exp_q.size() > 0) begin
            leftExp = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL tick_missing: got no tick, required edge=%0d baud=%0b mid=%0b phase=%0d",
                     leftExp[W-1:W-16], leftExp[PW+1], leftExp[PW], leftExp[PW-1:0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
